// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write master.
// Also holds the frame layout helper used at accept time.
package sccb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BITS  = 3'd2,
      STOP  = 3'd3,
      GAP   = 3'd4
   } sccb_state_e;

   localparam int START_TICKS    = 2;
   localparam int TICKS_PER_BIT  = 4;
   localparam int BITS_PER_PHASE = 9;
   localparam int PHASES         = 3;
   localparam int FRAME_BITS     = PHASES * BITS_PER_PHASE;
   localparam int STOP_TICKS     = 4;
   localparam int GAP_TICKS      = 4;

   localparam logic [7:0] OV7670_WRITE_ID = 8'h42;

   // Each phase is 8 data bits plus a don't-care bit sent as 1 (bus released).
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] id,
                                                          input logic [7:0] addr,
                                                          input logic [7:0] data);
      return {id, 1'b1, addr, 1'b1, data, 1'b1};
   endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick prescaler: counts 0..CLK_DIV-1 and pulses o_tick on wrap.
// A synchronous clear restarts the count so the first tick lands CLK_DIV cycles later.
module sccb_tick_gen #(
   parameter int CLK_DIV = 125
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] TC = W'(CLK_DIV - 1);

   logic [W-1:0] r_cnt;
   logic         w_wrap;

   assign w_wrap = (r_cnt == TC);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = w_wrap && !i_clear;

endmodule

// File: rtl/sccb_master.sv
// Single-register SCCB write master: ID, register address, register data.
// Bus outputs are registered from next-state values so they move with the state.
//
// state | meaning
// IDLE  | bus free, ready for a request
// START | SIOC high, SIOD low (start condition), 2 ticks
// BITS  | 27 frame bits, 4 ticks each, MSB first
// STOP  | SIOC low/low/high/high with SIOD rising on the last tick
// GAP   | bus free time, 4 ticks, then done pulse
module sccb_master
   import sccb_pkg::*;
#(
   parameter int         CLK_DIV    = 125,
   parameter logic [7:0] SLAVE_ADDR = OV7670_WRITE_ID
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_config_valid,
   output logic       io_config_ready,
   input  logic [7:0] io_reg_addr,
   input  logic [7:0] io_reg_data,
   output logic       io_busy,
   output logic       io_done,
   output logic       io_SIOC,
   output logic       io_SIOD
);

   localparam logic [1:0] START_LAST = 2'(START_TICKS - 1);
   localparam logic [1:0] BIT_LAST   = 2'(TICKS_PER_BIT - 1);
   localparam logic [1:0] STOP_LAST  = 2'(STOP_TICKS - 1);
   localparam logic [1:0] GAP_LAST   = 2'(GAP_TICKS - 1);
   localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);

   sccb_state_e           r_state;
   logic [1:0]            r_sub;
   logic [4:0]            r_bit_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_sioc;
   logic                  r_siod;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;

   sccb_state_e           w_state_nxt;
   logic [1:0]            w_sub_nxt;
   logic [4:0]            w_bit_nxt;
   logic [FRAME_BITS-1:0] w_shift_nxt;
   logic                  w_done_nxt;
   logic                  w_sioc_nxt;
   logic                  w_siod_nxt;
   logic                  w_accept;
   logic                  w_tick;

   assign w_accept = r_ready && io_config_valid;

   sccb_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clock   (clock),
      .reset   (reset),
      .i_clear (w_accept),
      .o_tick  (w_tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_sub     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_sioc    <= 1'b1;
         r_siod    <= 1'b1;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sub     <= w_sub_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_sioc    <= w_sioc_nxt;
         r_siod    <= w_siod_nxt;
         r_ready   <= (w_state_nxt == IDLE);
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sub_nxt   = r_sub;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = START;
               w_sub_nxt   = '0;
               w_bit_nxt   = '0;
               w_shift_nxt = build_frame(SLAVE_ADDR, io_reg_addr, io_reg_data);
            end
         end
         START: begin
            if (w_tick) begin
               if (r_sub == START_LAST) begin
                  w_state_nxt = BITS;
                  w_sub_nxt   = '0;
               end else begin
                  w_sub_nxt = r_sub + 1'b1;
               end
            end
         end
         BITS: begin
            if (w_tick) begin
               if (r_sub == BIT_LAST) begin
                  w_sub_nxt   = '0;
                  w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
                  if (r_bit_cnt == FRAME_LAST) begin
                     w_state_nxt = STOP;
                     w_bit_nxt   = '0;
                  end else begin
                     w_bit_nxt = r_bit_cnt + 1'b1;
                  end
               end else begin
                  w_sub_nxt = r_sub + 1'b1;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_sub == STOP_LAST) begin
                  w_state_nxt = GAP;
                  w_sub_nxt   = '0;
               end else begin
                  w_sub_nxt = r_sub + 1'b1;
               end
            end
         end
         GAP: begin
            if (w_tick) begin
               if (r_sub == GAP_LAST) begin
                  w_state_nxt = IDLE;
                  w_sub_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_sub_nxt = r_sub + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_sub_nxt   = '0;
            w_bit_nxt   = '0;
         end
      endcase
   end

   // SIOD only moves at tick 0 of a bit, together with SIOC falling.
   always_comb begin
      w_sioc_nxt = 1'b1;
      w_siod_nxt = 1'b1;
      case (w_state_nxt)
         START: begin
            w_siod_nxt = 1'b0;
         end
         BITS: begin
            w_sioc_nxt = w_sub_nxt[1];
            w_siod_nxt = w_shift_nxt[FRAME_BITS-1];
         end
         STOP: begin
            w_sioc_nxt = w_sub_nxt[1];
            w_siod_nxt = (w_sub_nxt == STOP_LAST);
         end
         default: begin
            w_sioc_nxt = 1'b1;
            w_siod_nxt = 1'b1;
         end
      endcase
   end

   assign io_config_ready = r_ready;
   assign io_busy         = r_busy;
   assign io_done         = r_done;
   assign io_SIOC         = r_sioc;
   assign io_SIOD         = r_siod;

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master at CLK_DIV=4: frame capture on SIOC rise,
// start/stop edge counting, latency, held-valid throughput and mid-write reset.
module tb_sccb_master;

   localparam int CLK_DIV = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] addr  = 8'h00;
   logic [7:0] data  = 8'h00;
   logic       ready, busy, done, sioc, siod;

   int checks   = 0;
   int failures = 0;

   sccb_master #(
      .CLK_DIV    (CLK_DIV),
      .SLAVE_ADDR (8'h42)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .io_config_valid (valid),
      .io_config_ready (ready),
      .io_reg_addr     (addr),
      .io_reg_data     (data),
      .io_busy         (busy),
      .io_done         (done),
      .io_SIOC         (sioc),
      .io_SIOD         (siod)
   );

   always #5 clock = ~clock;

   // Bus monitor: counts SIOD edges while SIOC stays high and shifts in SIOD on SIOC rise.
   logic        prev_sioc = 1'b1;
   logic        prev_siod = 1'b1;
   logic        prev_busy = 1'b0;
   logic [26:0] mon_frame = '0;
   int          mon_bits  = 0;
   int          mon_rises = 0;
   int          mon_fall  = 0;
   int          mon_rise  = 0;

   always @(negedge clock) begin
      if (busy && !prev_busy) begin
         mon_frame = '0;
         mon_bits  = 0;
         mon_rises = 0;
         mon_fall  = 0;
         mon_rise  = 0;
      end
      if (prev_sioc && sioc && (siod !== prev_siod)) begin
         if (siod) mon_rise++;
         else      mon_fall++;
      end
      if (busy && !prev_sioc && sioc) begin
         mon_rises++;
         if (mon_bits < 27) begin
            mon_frame = {mon_frame[25:0], siod};
            mon_bits++;
         end
      end
      prev_sioc = sioc;
      prev_siod = siod;
      prev_busy = busy;
   end

   task automatic send(input logic [7:0] a, input logic [7:0] d);
      @(negedge clock);
      valid = 1'b1;
      addr  = a;
      data  = d;
      @(posedge clock);
      #1 valid = 1'b0;
   endtask

   // Counts negedges after the accept edge until done; 1 = the busy-rise sample.
   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 2000) begin
         @(negedge clock);
         cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clock);
      checks++;
      if ({sioc, siod, ready, busy, done} !== 5'b11100) begin
         failures++;
         $display("FAIL reset_held: got sioc,siod,ready,busy,done=%b required 11100",
                  {sioc, siod, ready, busy, done});
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({sioc, siod, ready, busy, done} !== 5'b11100) begin
         failures++;
         $display("FAIL reset_release: got sioc,siod,ready,busy,done=%b required 11100",
                  {sioc, siod, ready, busy, done});
      end
   endtask

   task automatic test_idle_bus;
      int errs = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if ({sioc, siod, ready, busy, done} !== 5'b11100) errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL idle_bus: %0d bad cycles, required 0", errs);
      end
   endtask

   task automatic test_single_write;
      logic [26:0] exp = {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1};
      int  lat = 0;
      int  busy_drop = 0;
      bit  ok = 1'b0;
      send(8'h12, 8'h80);
      @(negedge clock);
      checks++;
      if ({busy, sioc, siod} !== 3'b110) begin
         failures++;
         $display("FAIL start_cond: got busy,sioc,siod=%b required 110", {busy, sioc, siod});
      end
      while (lat < 2000) begin
         @(negedge clock);
         lat++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (!busy) busy_drop++;
      end
      checks++;
      if (!ok || lat != 472) begin
         failures++;
         $display("FAIL single_latency: done %0d cycles after busy (seen=%0d) required 472", lat, ok);
      end
      checks++;
      if (busy_drop != 0) begin
         failures++;
         $display("FAIL single_busy_hold: busy low for %0d cycles required 0", busy_drop);
      end
      checks++;
      if ({ready, busy} !== 2'b10) begin
         failures++;
         $display("FAIL single_done_state: got ready,busy=%b required 10", {ready, busy});
      end
      checks++;
      if (mon_bits != 27 || mon_frame !== exp) begin
         failures++;
         $display("FAIL single_frame: got %h (%0d bits) required %h (27 bits)", mon_frame, mon_bits, exp);
      end
      checks++;
      if (mon_rises != 28) begin
         failures++;
         $display("FAIL single_sioc_rises: got %0d required 28", mon_rises);
      end
      checks++;
      if (mon_fall != 1 || mon_rise != 1) begin
         failures++;
         $display("FAIL single_start_stop: got falls=%0d rises=%0d required 1 and 1", mon_fall, mon_rise);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse_width: got done=%b required 0", done);
      end
   endtask

   task automatic test_input_change;
      logic [26:0] exp = {8'h42, 1'b1, 8'h5A, 1'b1, 8'hC3, 1'b1};
      int cyc = 0;
      bit ok = 1'b0;
      @(negedge clock);
      valid = 1'b1;
      addr  = 8'h5A;
      data  = 8'hC3;
      @(posedge clock);
      #1;
      valid = 1'b0;
      addr  = 8'hFF;
      data  = 8'h00;
      wait_done(cyc, ok);
      checks++;
      if (!ok || mon_frame !== exp) begin
         failures++;
         $display("FAIL input_change_frame: got %h (done=%0d) required %h", mon_frame, ok, exp);
      end
   endtask

   task automatic test_held_valid;
      logic [26:0] exp = {8'h42, 1'b1, 8'h11, 1'b1, 8'h01, 1'b1};
      int c = 0;
      int ready_bad = 0;
      bit second = 1'b0;
      bit done_at_accept = 1'b0;
      int cyc = 0;
      bit ok = 1'b0;
      @(negedge clock);
      valid = 1'b1;
      addr  = 8'h11;
      data  = 8'h01;
      while (c < 2000) begin
         @(negedge clock);
         c++;
         if (busy && ready) ready_bad++;
         if (ready && valid) begin
            second = 1'b1;
            done_at_accept = done;
            break;
         end
      end
      checks++;
      if (ready_bad != 0) begin
         failures++;
         $display("FAIL held_ready_low: ready high during busy %0d cycles required 0", ready_bad);
      end
      checks++;
      if (!second || c != 473) begin
         failures++;
         $display("FAIL held_accept_gap: got %0d cycles (seen=%0d) required 473", c, second);
      end
      checks++;
      if (done_at_accept !== 1'b1) begin
         failures++;
         $display("FAIL held_accept_in_done: done=%b at second accept required 1", done_at_accept);
      end
      @(posedge clock);
      #1 valid = 1'b0;
      wait_done(cyc, ok);
      checks++;
      if (!ok || cyc != 473 || mon_frame !== exp) begin
         failures++;
         $display("FAIL held_second_frame: got %h cyc=%0d required %h cyc=473", mon_frame, cyc, exp);
      end
   endtask

   task automatic test_reset_mid;
      logic [26:0] exp = {8'h42, 1'b1, 8'h3A, 1'b1, 8'h04, 1'b1};
      int  n = 0;
      bit  hit = 1'b0;
      int  cyc = 0;
      bit  ok = 1'b0;
      send(8'h00, 8'hFF);
      while (n < 2000) begin
         @(negedge clock);
         n++;
         if (mon_bits == 10 && sioc == 1'b0) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit || siod !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_reach_bit10: reached=%0d siod=%b required 1 and 0", hit, siod);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({sioc, siod, ready, busy, done} !== 5'b11100) begin
         failures++;
         $display("FAIL reset_mid_async: got sioc,siod,ready,busy,done=%b required 11100",
                  {sioc, siod, ready, busy, done});
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({sioc, siod, ready, busy} !== 4'b1110) begin
         failures++;
         $display("FAIL reset_mid_after: got sioc,siod,ready,busy=%b required 1110",
                  {sioc, siod, ready, busy});
      end
      send(8'h3A, 8'h04);
      wait_done(cyc, ok);
      checks++;
      if (!ok || cyc != 473 || mon_bits != 27 || mon_frame !== exp) begin
         failures++;
         $display("FAIL reset_mid_next_frame: got %h bits=%0d cyc=%0d required %h bits=27 cyc=473",
                  mon_frame, mon_bits, cyc, exp);
      end
      checks++;
      if (mon_fall != 1 || mon_rise != 1) begin
         failures++;
         $display("FAIL reset_mid_start_stop: got falls=%0d rises=%0d required 1 and 1", mon_fall, mon_rise);
      end
   endtask

   initial begin
      test_reset();
      test_idle_bus();
      test_single_write();
      test_input_change();
      test_held_valid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
